trigger_interval_timer: RTL and testbench

- Measures the cycle interval between a trigger edge and the returning event edge, e.g. an echo or the delayed trigger arriving at the far end.
- It is the receive-side counterpart to the trigger delay generators in the capture chain.
- It sits after the trigger/echo inputs and feeds a measured count plus valid/timeout pulses to the control logic.

---
 rtl/trigger_pkg.sv | 15 +
 rtl/trigger_interval_timer_rise_detect.sv | 48 ++++
 rtl/trigger_interval_timer.sv | 122 ++++++++++++
 tb/tb_trigger_interval_timer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger delay / interval blocks of the capture chain.
//   trig_state_t           : measurement state (IDLE, COUNT)
//   DEFAULT_CNT_W          : default interval counter width
//   DEFAULT_TIMEOUT_CYCLES : default abort interval (fits DEFAULT_CNT_W)
package trigger_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } trig_state_t;

    localparam int unsigned DEFAULT_CNT_W          = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

endpackage : trigger_pkg

// File: rtl/trigger_interval_timer_rise_detect.sv
// Rising-edge detector for one strobe input, with an optional 2-flop
// synchronizer in front (enabled by macro TRIGGER_INTERVAL_SYNC_EN).
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   din    : raw strobe input
//   rise_c : combinational one-cycle flag, high when the (synchronized) level
//            is 1 and was 0 on the previous cycle
module trigger_interval_timer_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c
);

    logic level;
    logic prev_q;

`ifdef TRIGGER_INTERVAL_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign level = sync_q[1];
`else
    assign level = din;
`endif

    // History flop: reset loads the present level so a level already high
    // when reset releases is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= level;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_c = level & ~prev_q;

endmodule : trigger_interval_timer_rise_detect

// File: rtl/trigger_interval_timer.sv
// Measures the cycle count between a trigger rising edge and the following
// event rising edge, reporting a latency-compensated result or a timeout.
// Optional macro: TRIGGER_INTERVAL_SYNC_EN adds 2-flop synchronizers on both
// inputs (interval unchanged, pulses appear 2 cycles later).
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high
//   trigger_in   : start strobe (rising edge starts a measurement)
//   event_in     : stop strobe (rising edge ends a measurement)
//   busy         : high while a measurement is in progress
//   result       : last compensated interval, held until the next valid one
//   result_valid : one-cycle pulse when result updates
//   timeout      : one-cycle pulse when a measurement aborts
module trigger_interval_timer
    import trigger_pkg::*;
#(
    parameter int unsigned CNT_W          = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned LATENCY_COMP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger_in,
    input  logic             event_in,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] COMP_VAL    = CNT_W'(LATENCY_COMP);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic trig_rise_c;
    logic evt_rise_c;

    trig_state_t      state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             valid_q,  valid_d;
    logic             tmo_q,    tmo_d;

    trigger_interval_timer_rise_detect u_trig_rise (
        .clk    (clk),
        .reset  (reset),
        .din    (trigger_in),
        .rise_c (trig_rise_c)
    );

    trigger_interval_timer_rise_detect u_evt_rise (
        .clk    (clk),
        .reset  (reset),
        .din    (event_in),
        .rise_c (evt_rise_c)
    );

    // State and output registers; reset aborts any measurement silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic. An event on the timeout cycle still counts as a
    // valid measurement; the counter stops at TIMEOUT_VAL so it never wraps.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        tmo_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_rise_c) begin
                    state_d = COUNT;
                    count_d = ONE;
                    busy_d  = 1'b1;
                end
            end
            COUNT: begin
                if (evt_rise_c) begin
                    result_d = (count_q > COMP_VAL) ? (count_q - COMP_VAL) : '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (count_q == TIMEOUT_VAL) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = tmo_q;

endmodule : trigger_interval_timer

// File: tb/tb_trigger_interval_timer.sv
// Scoreboard bench for trigger_interval_timer (default build, no synchronizer).
// Two instances share the stimulus:
//   dut_a : LATENCY_COMP=0, TIMEOUT_CYCLES=8
//   dut_b : LATENCY_COMP=3, TIMEOUT_CYCLES=12
// cyc counts rising edges; outputs are sampled on the falling edge, so a
// pulse caused by edge n is seen when cyc == n.
module tb_trigger_interval_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger_in;
    logic        event_in;

    logic        busy_a, valid_a, tmo_a;
    logic [15:0] result_a;
    logic        busy_b, valid_b, tmo_b;
    logic [15:0] result_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_to;
        logic [15:0] val;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trigger_interval_timer #(
        .CNT_W(16), .TIMEOUT_CYCLES(8), .LATENCY_COMP(0)
    ) dut_a (
        .clk(clk), .reset(reset), .trigger_in(trigger_in), .event_in(event_in),
        .busy(busy_a), .result(result_a), .result_valid(valid_a), .timeout(tmo_a)
    );

    trigger_interval_timer #(
        .CNT_W(16), .TIMEOUT_CYCLES(12), .LATENCY_COMP(3)
    ) dut_b (
        .clk(clk), .reset(reset), .trigger_in(trigger_in), .event_in(event_in),
        .busy(busy_b), .result(result_b), .result_valid(valid_b), .timeout(tmo_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    task automatic exp_a(input bit is_to, input int val, input int at);
        exp_t e;
        e.is_to = is_to; e.val = 16'(val); e.at = at;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input bit is_to, input int val, input int at);
        exp_t e;
        e.is_to = is_to; e.val = 16'(val); e.at = at;
        q_b.push_back(e);
    endtask

    // Monitor for dut_a
    always @(negedge clk) begin
        if (valid_a || tmo_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL mon_a: unexpected pulse valid=%0b timeout=%0b result=%0d at cyc %0d",
                         valid_a, tmo_a, result_a, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (tmo_a !== e.is_to || valid_a === tmo_a || result_a !== e.val || cyc != e.at) begin
                    errors++;
                    $display("FAIL mon_a: got valid=%0b timeout=%0b result=%0d at cyc %0d, want timeout=%0b result=%0d at cyc %0d",
                             valid_a, tmo_a, result_a, cyc, e.is_to, e.val, e.at);
                end
            end
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        if (valid_b || tmo_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL mon_b: unexpected pulse valid=%0b timeout=%0b result=%0d at cyc %0d",
                         valid_b, tmo_b, result_b, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (tmo_b !== e.is_to || valid_b === tmo_b || result_b !== e.val || cyc != e.at) begin
                    errors++;
                    $display("FAIL mon_b: got valid=%0b timeout=%0b result=%0d at cyc %0d, want timeout=%0b result=%0d at cyc %0d",
                             valid_b, tmo_b, result_b, cyc, e.is_to, e.val, e.at);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        trigger_in = 1'b0;
        event_in   = 1'b0;

        // Reset values
        wait_cyc(3);
        chk("rst_busy_a",   32'(busy_a),   0);
        chk("rst_result_a", 32'(result_a), 0);
        chk("rst_valid_a",  32'(valid_a),  0);
        chk("rst_tmo_a",    32'(tmo_a),    0);
        chk("rst_busy_b",   32'(busy_b),   0);
        chk("rst_result_b", 32'(result_b), 0);
        wait_cyc(4);
        reset = 1'b0;

        // S1: trigger edge 10, event edge 15 -> D=5
        exp_a(0, 5, 15);
        exp_b(0, 2, 15);
        wait_cyc(9);
        trigger_in = 1'b1;
        chk("s1_busy_before", 32'(busy_a), 0);
        for (int k = 10; k <= 14; k++) begin
            wait_cyc(k);
            if (k == 10) trigger_in = 1'b0;
            if (k == 14) event_in = 1'b1;
            chk("s1_busy_during", 32'(busy_a), 1);
        end
        wait_cyc(15);
        event_in = 1'b0;
        chk("s1_busy_after_a", 32'(busy_a), 0);
        chk("s1_busy_after_b", 32'(busy_b), 0);

        // S2: D=2 -> A=2, B saturates to 0
        exp_a(0, 2, 22);
        exp_b(0, 0, 22);
        wait_cyc(19); trigger_in = 1'b1;
        wait_cyc(20); trigger_in = 1'b0;
        wait_cyc(21); event_in = 1'b1;
        wait_cyc(22); event_in = 1'b0;

        // S3: D=10 -> A times out at 8 (result kept 2), B gives 7
        exp_a(1, 2, 38);
        exp_b(0, 7, 40);
        wait_cyc(29); trigger_in = 1'b1;
        wait_cyc(30); trigger_in = 1'b0;
        wait_cyc(38);
        chk("s3_busy_a_dropped", 32'(busy_a), 0);
        chk("s3_busy_b_held",    32'(busy_b), 1);
        wait_cyc(39); event_in = 1'b1;
        wait_cyc(40); event_in = 1'b0;

        // S4: event exactly at D=TIMEOUT(8) on A -> valid 8, no timeout
        exp_a(0, 8, 58);
        exp_b(0, 5, 58);
        wait_cyc(49); trigger_in = 1'b1;
        wait_cyc(50); trigger_in = 1'b0;
        wait_cyc(57); event_in = 1'b1;
        wait_cyc(58); event_in = 1'b0;

        // S5: no event -> both time out, results held
        exp_a(1, 8, 78);
        exp_b(1, 5, 82);
        wait_cyc(69); trigger_in = 1'b1;
        wait_cyc(70); trigger_in = 1'b0;
        wait_cyc(82);
        chk("s5_busy_a", 32'(busy_a), 0);
        chk("s5_busy_b", 32'(busy_b), 0);

        // S6: retrigger at edge 93 ignored, event at 96 -> D=6
        exp_a(0, 6, 96);
        exp_b(0, 3, 96);
        wait_cyc(89); trigger_in = 1'b1;
        wait_cyc(90); trigger_in = 1'b0;
        wait_cyc(92); trigger_in = 1'b1;
        wait_cyc(93); trigger_in = 1'b0;
        wait_cyc(95); event_in = 1'b1;
        wait_cyc(96); event_in = 1'b0;

        // S7: trigger and event together in IDLE; event discarded, next at 104 -> D=4
        exp_a(0, 4, 104);
        exp_b(0, 1, 104);
        wait_cyc(99);  trigger_in = 1'b1; event_in = 1'b1;
        wait_cyc(100); trigger_in = 1'b0; event_in = 1'b0;
        wait_cyc(103); event_in = 1'b1;
        wait_cyc(104); event_in = 1'b0;

        // S8: back-to-back: D=3 ending at 113, new trigger at 114, D=5 ending at 119
        exp_a(0, 3, 113);
        exp_b(0, 0, 113);
        exp_a(0, 5, 119);
        exp_b(0, 2, 119);
        wait_cyc(109); trigger_in = 1'b1;
        wait_cyc(110); trigger_in = 1'b0;
        wait_cyc(112); event_in = 1'b1;
        wait_cyc(113); event_in = 1'b0; trigger_in = 1'b1;
        wait_cyc(114); trigger_in = 1'b0;
        wait_cyc(118); event_in = 1'b1;
        wait_cyc(119); event_in = 1'b0;

        // S9: reset during COUNT -> silent abort, result cleared
        wait_cyc(129); trigger_in = 1'b1;
        wait_cyc(130); trigger_in = 1'b0;
        wait_cyc(133);
        chk("s9_busy_a_pre", 32'(busy_a), 1);
        chk("s9_busy_b_pre", 32'(busy_b), 1);
        reset = 1'b1;
        wait_cyc(134);
        reset = 1'b0;
        chk("s9_busy_a",   32'(busy_a),   0);
        chk("s9_result_a", 32'(result_a), 0);
        chk("s9_busy_b",   32'(busy_b),   0);
        chk("s9_result_b", 32'(result_b), 0);
        wait_cyc(145);

        // S10: trigger held high through reset release -> no measurement
        wait_cyc(149); trigger_in = 1'b1; reset = 1'b1;
        wait_cyc(151); reset = 1'b0;
        wait_cyc(152);
        chk("s10_busy_a_152", 32'(busy_a), 0);
        chk("s10_busy_b_152", 32'(busy_b), 0);
        wait_cyc(155);
        chk("s10_busy_a_155", 32'(busy_a), 0);
        trigger_in = 1'b0;

        // S11: fresh measurement after resets, D=5
        exp_a(0, 5, 165);
        exp_b(0, 2, 165);
        wait_cyc(159); trigger_in = 1'b1;
        wait_cyc(160); trigger_in = 1'b0;
        wait_cyc(164); event_in = 1'b1;
        wait_cyc(165); event_in = 1'b0;

        wait_cyc(175);
        chk("pending_a", 32'(q_a.size()), 0);
        chk("pending_b", 32'(q_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_trigger_interval_timer
